// File: rtl/scanline_irq_controller.sv
// MMC3-style scanline IRQ sequencer clocked by CPU M2: synchronizes and filters PPU A12
// rises, counts scanlines against a CPU-programmed latch and drives a registered IRQ.
module scanline_irq_controller #(
    parameter int LOW_CYCLES  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic       m2,
    input  logic       rst_n,
    input  logic       ppu_a12,
    input  logic       reg_we,
    input  logic [1:0] reg_sel,
    input  logic [7:0] reg_data,
    output logic       irq_n,
    output logic [7:0] counter,
    output logic       a12_event
);
    localparam int CW = $clog2(LOW_CYCLES + 1);
    localparam logic [CW-1:0] LOW_MAX = CW'(LOW_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   a12_prev_q;
    logic [CW-1:0]          low_cnt_q, low_cnt_d;
    logic [7:0]             latch_q, latch_d;
    logic [7:0]             counter_q, counter_d;
    logic                   reload_q, reload_d;
    logic                   enabled_q, enabled_d;
    logic                   irq_pend_q, irq_pend_d;
    logic                   a12_event_q;
    logic                   irq_n_q;
    logic                   a12_s;
    logic                   ev;

    assign a12_s = sync_q[SYNC_STAGES-1];
    // A rise counts only after LOW_CYCLES synced-low samples; short gaps (8x16 sprites) are ignored.
    assign ev    = a12_s & ~a12_prev_q & (low_cnt_q == LOW_MAX);

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], ppu_a12};
        low_cnt_d  = low_cnt_q;
        latch_d    = latch_q;
        counter_d  = counter_q;
        reload_d   = reload_q;
        enabled_d  = enabled_q;
        irq_pend_d = irq_pend_q;

        if (a12_s) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != LOW_MAX) begin
            low_cnt_d = low_cnt_q + CW'(1);
        end

        if (ev) begin
            if (counter_q == 8'd0 || reload_q) begin
                counter_d = latch_q;
                reload_d  = 1'b0;
            end else begin
                counter_d = counter_q - 8'd1;
            end
            if (counter_d == 8'd0 && enabled_q) begin
                irq_pend_d = 1'b1;
            end
        end

        // Register writes are applied after the event so they win on the same cycle.
        if (reg_we) begin
            unique case (reg_sel)
                2'b00: latch_d = reg_data;
                2'b01: reload_d = 1'b1;
                2'b10: begin
                    enabled_d  = 1'b0;
                    irq_pend_d = 1'b0;
                end
                2'b11: enabled_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            a12_prev_q  <= 1'b0;
            low_cnt_q   <= '0;
            latch_q     <= 8'd0;
            counter_q   <= 8'd0;
            reload_q    <= 1'b0;
            enabled_q   <= 1'b0;
            irq_pend_q  <= 1'b0;
            a12_event_q <= 1'b0;
            irq_n_q     <= 1'b1;
        end else begin
            sync_q      <= sync_d;
            a12_prev_q  <= a12_s;
            low_cnt_q   <= low_cnt_d;
            latch_q     <= latch_d;
            counter_q   <= counter_d;
            reload_q    <= reload_d;
            enabled_q   <= enabled_d;
            irq_pend_q  <= irq_pend_d;
            a12_event_q <= ev;
            irq_n_q     <= ~irq_pend_q;
        end
    end

    assign irq_n     = irq_n_q;
    assign counter   = counter_q;
    assign a12_event = a12_event_q;
endmodule

// File: doc/scanline_irq_controller.md
Name: scanline_irq_controller

Overview:
- Synchronous MMC3-compatible scanline IRQ sequencer for the multicart mapper core, clocked by CPU M2.
- Filters PPU A12 rising edges, counts scanlines against a CPU-programmed latch, and drives the cartridge IRQ line.
- The mapper's $C000-$FFFF register decoder drives the write port with one-cycle strobes.
- Replaces the current asynchronous counter logic, which is clocked by A12 and uses a combinational IRQ latch.

Parameters:
- LOW_CYCLES, 3: consecutive M2 rising edges with synced A12 low required before an A12 rise counts.
- SYNC_STAGES, 2: synchronizer depth for ppu_a12 (minimum 2).

Ports:
- m2  input  1  CPU M2. Single clock; all state updates on its rising edge.
- rst_n  input  1  Reset, asynchronous and active-low.
- ppu_a12  input  1  Raw PPU A12. Asynchronous to m2.
- reg_we  input  1  Register write strobe. Valid for one m2 cycle.
- reg_sel  input  2  Register select: 00 = latch ($C000), 01 = reload ($C001), 10 = disable/ack ($E000), 11 = enable ($E001).
- reg_data  input  8  Write data. Used only when reg_sel = 00.
- irq_n  output  1  Registered active-low IRQ request. Board logic converts it to open-drain.
- counter  output  8  Current scanline counter (debug/readback).
- a12_event  output  1  One-cycle pulse when a filtered A12 rise is accepted.

Behaviour:
- Reset (async assert, sync release) clears: synchronizer flops 0, a12_prev 0, low_cnt 0, latch 0x00, counter 0x00, reload_pending 0, enabled 0, irq_pending 0, a12_event 0. irq_n resets to 1.
- Synchronizer: ppu_a12 passes through SYNC_STAGES flops to give a12_s; a12_prev holds a12_s delayed one cycle.
- Low filter (low_cnt):
  - a12_s = 1 -> low_cnt <= 0.
  - a12_s = 0 -> low_cnt <= min(low_cnt + 1, LOW_CYCLES); saturates, never wraps.
- Event: ev = a12_s & ~a12_prev & (low_cnt == LOW_CYCLES).
  - a12_event is ev, registered. It is high exactly one cycle after the detected edge.
  - A12 high pulses with less than LOW_CYCLES low time between them produce no event (8x16 sprite fetch suppression).
- Latency: a raw ppu_a12 rise sampled at cycle N sets ev at cycle N+SYNC_STAGES. counter updates and a12_event asserts on that edge. irq_n falls one cycle later.
- Counter update on ev:
  - counter == 0 or reload_pending = 1 -> counter <= latch, reload_pending <= 0.
  - Otherwise counter <= counter - 1.
  - 8-bit; underflow is impossible because 0 always reloads.
  - If the post-update value is 0 and enabled = 1 -> irq_pending <= 1.
- Writes (reg_we = 1):
  - 00: latch <= reg_data. Does not touch counter.
  - 01: reload_pending <= 1. counter is unchanged until the next ev.
  - 10: enabled <= 0, irq_pending <= 0 (acknowledge).
  - 11: enabled <= 1. Does not assert IRQ retroactively.
- irq_n <= ~irq_pending (registered). Once asserted, irq_pending holds until a 10 write or reset; further events do not clear it.
- Same-cycle ev and write:
  - ev uses the pre-write latch, reload_pending and enabled.
  - 01 write with ev: reload_pending ends at 1 (write wins over ev's clear).
  - 10 write with ev that would raise IRQ: irq_pending ends at 0 (disable wins).
  - 11 write with ev: ev uses old enabled (0), so no IRQ that cycle.
- latch = 0: every ev leaves counter at 0, so IRQ fires on every ev while enabled.
- Reset mid-operation: all state returns to reset values immediately. irq_n deasserts asynchronously.

Test Plan:
- Reset, write latch = 3 and enable, then issue 5 clean A12 rises, each preceded by >=3 low m2 cycles -> counter goes 3, 2, 1, 0, 3; irq_n falls one cycle after the 4th a12_event; a 10 write returns irq_n to 1 the next cycle.
- A12 pulses with only 2 low cycles between them -> a12_event never asserts, counter unchanged; then 3 low cycles followed by a rise -> exactly one event.
- Latch = 0, enabled -> irq_n falls after the first event; ack via a 10 write, then re-enable with an 11 write -> irq_n falls again after the next event.
- counter = 2, latch = 7, write 01, then one event -> counter = 7, reload_pending clears; the next event gives 6.
- Counter at 1, enabled, and a 10 write landing in the same cycle as ev -> counter = 0, irq_n stays 1.
- Assert rst_n = 0 while irq_n = 0 and counter = 5 -> irq_n = 1 and counter = 0 without an m2 edge; after release, the first A12 rise needs 3 low cycles before it counts.
